// File: rtl/root_comp_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : root_comp_sequencer_if
// Description : Host bus, LOCAL-port receive and root-router transmit signals
//               of the root computation sequencer.
//               slave  - sequencer side (consumes host/LOCAL, drives router)
//               master - host / environment side
//   write_en/addr/data, write_rdy : host register/CONFIG write handshake
//   read_en/addr, read_rdy        : host READ handshake
//   in_data_valid, in_data        : LOCAL port packets {info,addr,data}
//   router_rdy                    : root router can accept a packet
//   comp_tx_en, comp_tx_data      : packet issued to the root router
// Revision    : 1.0  initial release
// ============================================================================
interface root_comp_sequencer_if #(
  parameter int INFO_W = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  localparam int c_PKT_W = INFO_W + ADDR_W + DATA_W;

  logic                write_en;
  logic [ADDR_W-1:0]   write_addr;
  logic [DATA_W-1:0]   write_data;
  logic                write_rdy;
  logic                read_en;
  logic [ADDR_W-1:0]   read_addr;
  logic                read_rdy;
  logic                in_data_valid;
  logic [c_PKT_W-1:0]  in_data;
  logic                router_rdy;
  logic                comp_tx_en;
  logic [c_PKT_W-1:0]  comp_tx_data;

  modport slave (
    input  write_en, write_addr, write_data, read_en, read_addr,
    input  in_data_valid, in_data, router_rdy,
    output write_rdy, read_rdy, comp_tx_en, comp_tx_data
  );

  modport master (
    output write_en, write_addr, write_data, read_en, read_addr,
    output in_data_valid, in_data, router_rdy,
    input  write_rdy, read_rdy, comp_tx_en, comp_tx_data
  );
endinterface
`default_nettype wire

// File: rtl/root_comp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : root_comp_sequencer
// Description : Root-node computation sequencer. Turns host writes/reads into
//               CONFIG/READ packets, runs CALC -> FIN_BROADCAST -> FIN_COMP
//               rounds over NUM_PE PEs for layer_no layers, tracks per-PE FIN
//               reports in a bitmap, and raises a sticky cause-coded interrupt
//               on completion, watchdog timeout or protocol error.
// Ports       : clk, rst_n (async, active low)
//               bus        : root_comp_sequencer_if.slave (host + router side)
//               layer_idx  : current layer index
//               interrupt  : sticky interrupt level
//               irq_cause  : 0 none, 1 done, 2 timeout, 3 protocol error
// Revision    : 1.0  initial release
// ============================================================================
module root_comp_sequencer #(
  parameter int NUM_PE  = 64,
  parameter int LAYER_W = 4,
  parameter int INFO_W  = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TMO_W   = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  root_comp_sequencer_if.slave bus,
  output logic [LAYER_W-1:0]   layer_idx,
  output logic                 interrupt,
  output logic [1:0]           irq_cause
);
  localparam int c_PKT_W = INFO_W + ADDR_W + DATA_W;
  localparam int c_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  // Packet type codes carried in the info field
  localparam logic [INFO_W-1:0] c_INFO_CONFIG = INFO_W'(1);
  localparam logic [INFO_W-1:0] c_INFO_READ   = INFO_W'(2);
  localparam logic [INFO_W-1:0] c_INFO_CALC   = INFO_W'(3);
  localparam logic [INFO_W-1:0] c_INFO_FIN_BC = INFO_W'(4);
  localparam logic [INFO_W-1:0] c_INFO_FIN_CP = INFO_W'(5);

  localparam logic [ADDR_W-1:0] c_ADDR_LAYER   = '0;
  localparam logic [ADDR_W-1:0] c_ADDR_START   = '1;
  localparam logic [ADDR_W-1:0] c_ADDR_IRQ_CLR = ~ADDR_W'(1);

  localparam logic [DATA_W:0]   c_NUM_PE    = (DATA_W+1)'(NUM_PE);
  localparam logic [NUM_PE-1:0] c_ALL_DONE  = '1;
  // Expiry fires on the edge that would take wdog to all-ones, so the
  // sequencer spends exactly 2^TMO_W-1 idle cycles in a WAIT state.
  localparam logic [TMO_W-1:0]  c_WDOG_LAST = ~TMO_W'(1);

  localparam logic [1:0] c_CAUSE_NONE  = 2'd0;
  localparam logic [1:0] c_CAUSE_DONE  = 2'd1;
  localparam logic [1:0] c_CAUSE_TMO   = 2'd2;
  localparam logic [1:0] c_CAUSE_PROTO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_BC = 3'd1,
    S_SEND_BC = 3'd2,
    S_WAIT_CP = 3'd3,
    S_SEND_CP = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [LAYER_W-1:0]   r_layer_no, w_layer_no_nxt;
  logic [LAYER_W-1:0]   r_layer_idx, w_layer_idx_nxt;
  logic [NUM_PE-1:0]    r_bitmap, w_bitmap_nxt;
  logic [TMO_W-1:0]     r_wdog;
  logic                 r_interrupt, w_interrupt_nxt;
  logic [1:0]           r_irq_cause, w_irq_cause_nxt;
  logic                 w_wdog_clr, w_wdog_inc;
  logic                 w_tx_en;
  logic [INFO_W-1:0]    w_tx_info;
  logic [ADDR_W-1:0]    w_tx_addr;
  logic [DATA_W-1:0]    w_tx_data;

  // ---------------------------------------------------------------- decode
  logic [INFO_W-1:0]  w_in_info;
  logic [DATA_W-1:0]  w_in_id;
  logic [c_IDX_W-1:0] w_id_idx;
  logic [NUM_PE-1:0]  w_fin_mask;
  logic               w_id_in_range, w_fin_dup, w_fin_hit;
  logic               w_idle, w_base_rdy, w_irq_clr_req, w_wr_acc, w_rd_acc;
  logic [ADDR_W-1:0]  w_unused_in_addr;

  assign w_in_info        = bus.in_data[c_PKT_W-1 -: INFO_W];
  assign w_unused_in_addr = bus.in_data[DATA_W +: ADDR_W];
  assign w_in_id          = bus.in_data[DATA_W-1:0];
  assign w_id_idx         = w_in_id[c_IDX_W-1:0];
  assign w_id_in_range    = ({1'b0, w_in_id} < c_NUM_PE);
  assign w_fin_mask       = NUM_PE'(1) << w_id_idx;
  assign w_fin_dup        = |(r_bitmap & w_fin_mask);
  // Each WAIT state only listens to its own FIN type; everything else is ignored
  assign w_fin_hit = bus.in_data_valid &&
                     (w_in_info == ((r_state == S_WAIT_BC) ? c_INFO_FIN_BC : c_INFO_FIN_CP));

  // Host handshake: an IDLE packet needs the router; irq-clear needs nothing
  // and is therefore taken in ERROR (and IDLE) regardless of router_rdy.
  assign w_idle        = (r_state == S_IDLE);
  assign w_base_rdy    = bus.router_rdy & w_idle;
  assign w_irq_clr_req = bus.write_en & (bus.write_addr == c_ADDR_IRQ_CLR);
  assign bus.write_rdy = w_base_rdy | (w_irq_clr_req & (w_idle | (r_state == S_ERROR)));
  // A pending write takes the router slot, so the read waits a cycle
  assign bus.read_rdy  = w_base_rdy & ~bus.write_en;
  assign w_wr_acc      = bus.write_en & bus.write_rdy;
  assign w_rd_acc      = bus.read_en & bus.read_rdy;

  // ------------------------------------------------------- next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_layer_no_nxt  = r_layer_no;
    w_layer_idx_nxt = r_layer_idx;
    w_bitmap_nxt    = r_bitmap;
    w_interrupt_nxt = r_interrupt;
    w_irq_cause_nxt = r_irq_cause;
    w_wdog_clr      = 1'b0;
    w_wdog_inc      = 1'b0;
    w_tx_en         = 1'b0;
    w_tx_info       = '0;
    w_tx_addr       = '0;
    w_tx_data       = '0;

    case (r_state)
      S_IDLE: begin
        if (w_wr_acc) begin
          if (bus.write_addr == c_ADDR_START) begin
            w_tx_en         = 1'b1;
            w_tx_info       = c_INFO_CALC;
            w_bitmap_nxt    = '0;
            w_layer_idx_nxt = '0;
            w_interrupt_nxt = 1'b0;
            w_irq_cause_nxt = c_CAUSE_NONE;
            w_state_nxt     = S_WAIT_BC;
          end else if (bus.write_addr == c_ADDR_IRQ_CLR) begin
            w_interrupt_nxt = 1'b0;
            w_irq_cause_nxt = c_CAUSE_NONE;
          end else begin
            w_tx_en   = 1'b1;
            w_tx_info = c_INFO_CONFIG;
            w_tx_addr = bus.write_addr;
            w_tx_data = bus.write_data;
            if (bus.write_addr == c_ADDR_LAYER) begin
              // A zero layer count would never match layer_no-1; treat as one
              w_layer_no_nxt = (bus.write_data[LAYER_W-1:0] == '0) ?
                               LAYER_W'(1) : bus.write_data[LAYER_W-1:0];
            end
          end
        end else if (w_rd_acc) begin
          w_tx_en   = 1'b1;
          w_tx_info = c_INFO_READ;
          w_tx_addr = bus.read_addr;
        end
      end

      S_WAIT_BC, S_WAIT_CP: begin
        // A FIN in the expiry cycle is handled first: completion beats timeout
        if (w_fin_hit) begin
          w_wdog_clr = 1'b1;
          if (!w_id_in_range || w_fin_dup) begin
            w_interrupt_nxt = 1'b1;
            w_irq_cause_nxt = c_CAUSE_PROTO;
            w_state_nxt     = S_ERROR;
          end else begin
            w_bitmap_nxt = r_bitmap | w_fin_mask;
            if (w_bitmap_nxt == c_ALL_DONE)
              w_state_nxt = (r_state == S_WAIT_BC) ? S_SEND_BC : S_SEND_CP;
          end
        end else if (r_wdog == c_WDOG_LAST) begin
          w_interrupt_nxt = 1'b1;
          w_irq_cause_nxt = c_CAUSE_TMO;
          w_state_nxt     = S_ERROR;
        end else begin
          w_wdog_inc = 1'b1;
        end
      end

      S_SEND_BC: begin
        if (bus.router_rdy) begin
          w_tx_en      = 1'b1;
          w_tx_info    = c_INFO_FIN_BC;
          w_bitmap_nxt = '0;
          w_state_nxt  = S_WAIT_CP;
        end
      end

      S_SEND_CP: begin
        if (bus.router_rdy) begin
          w_tx_en      = 1'b1;
          w_tx_info    = c_INFO_FIN_CP;
          w_bitmap_nxt = '0;
          if (r_layer_idx == (r_layer_no - LAYER_W'(1))) begin
            w_interrupt_nxt = 1'b1;
            w_irq_cause_nxt = c_CAUSE_DONE;
            w_state_nxt     = S_IDLE;
          end else begin
            w_layer_idx_nxt = r_layer_idx + LAYER_W'(1);
            w_state_nxt     = S_WAIT_BC;
          end
        end
      end

      S_ERROR: begin
        // Only an irq-clear can be accepted here
        if (w_wr_acc) begin
          w_bitmap_nxt    = '0;
          w_interrupt_nxt = 1'b0;
          w_irq_cause_nxt = c_CAUSE_NONE;
          w_state_nxt     = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_layer_no  <= LAYER_W'(1);
      r_layer_idx <= '0;
      r_bitmap    <= '0;
      r_wdog      <= '0;
      r_interrupt <= 1'b0;
      r_irq_cause <= c_CAUSE_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_layer_no  <= w_layer_no_nxt;
      r_layer_idx <= w_layer_idx_nxt;
      r_bitmap    <= w_bitmap_nxt;
      r_interrupt <= w_interrupt_nxt;
      r_irq_cause <= w_irq_cause_nxt;
      if (w_wdog_clr || (w_state_nxt != r_state))
        r_wdog <= '0;
      else if (w_wdog_inc)
        r_wdog <= r_wdog + TMO_W'(1);
    end
  end

  assign bus.comp_tx_en   = w_tx_en;
  assign bus.comp_tx_data = {w_tx_info, w_tx_addr, w_tx_data};
  assign layer_idx        = r_layer_idx;
  assign interrupt        = r_interrupt;
  assign irq_cause        = r_irq_cause;
endmodule
`default_nettype wire

// File: tb/tb_root_comp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_root_comp_sequencer
// Description : Self-checking bench for root_comp_sequencer (NUM_PE=4,
//               TMO_W=4). A per-cycle vector table covers a full two-layer
//               run and the host handshake; hand-written sequences cover
//               router stall, reset mid-run, completion racing the watchdog,
//               duplicate / out-of-range FIN ids and timeout.
// Revision    : 1.0  initial release
// ============================================================================
module tb_root_comp_sequencer;
  localparam int NUM_PE = 4, LAYER_W = 4, INFO_W = 4, ADDR_W = 16, DATA_W = 16, TMO_W = 4;

  localparam logic [3:0]  I_CFG = 4'd1, I_RD = 4'd2, I_CALC = 4'd3, I_FBC = 4'd4, I_FCP = 4'd5;
  localparam logic [15:0] A_START = 16'hFFFF, A_CLR = 16'hFFFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  root_comp_sequencer_if #(.INFO_W(INFO_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [LAYER_W-1:0] layer_idx;
  logic               interrupt;
  logic [1:0]         irq_cause;

  root_comp_sequencer #(
    .NUM_PE(NUM_PE), .LAYER_W(LAYER_W), .INFO_W(INFO_W),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .layer_idx(layer_idx), .interrupt(interrupt), .irq_cause(irq_cause)
  );

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [35:0] pkt(input logic [3:0] i, input logic [15:0] a, input logic [15:0] d);
    return {i, a, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [36:0] tx_now();
    return {bus.comp_tx_en, bus.comp_tx_en ? bus.comp_tx_data : 36'd0};
  endfunction

  // Host write held for one cycle; checks the packet issued in that cycle
  task automatic host_write(input logic [15:0] a, input logic [15:0] d,
                            input logic ex, input logic [35:0] ep, input string nm);
    bus.write_en = 1'b1; bus.write_addr = a; bus.write_data = d;
    #4 chk(nm, tx_now(), {ex, ex ? ep : 36'd0});
    tick();
    bus.write_en = 1'b0;
  endtask

  task automatic send_fin(input logic [3:0] info, input logic [15:0] id);
    bus.in_data_valid = 1'b1; bus.in_data = pkt(info, 16'h0, id);
    tick();
    bus.in_data_valid = 1'b0; bus.in_data = '0;
  endtask

  task automatic expect_tx(input string nm, input logic [35:0] p);
    #4 chk(nm, tx_now(), {1'b1, p});
    tick();
  endtask

  typedef struct {
    logic we; logic [15:0] wa; logic [15:0] wd; logic re; logic [15:0] ra;
    logic iv; logic [35:0] ind; logic rr;
    logic x_wr; logic x_rd; logic x_tx; logic [35:0] x_pkt;
    logic x_irq; logic [1:0] x_cause; logic [3:0] x_idx;
  } vec_t;

  function automatic vec_t v(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                             input logic re, input logic [15:0] ra, input logic iv,
                             input logic [35:0] ind, input logic rr, input logic x_wr,
                             input logic x_rd, input logic x_tx, input logic [35:0] x_pkt,
                             input logic x_irq, input logic [1:0] x_cause, input logic [3:0] x_idx);
    vec_t r;
    r.we = we; r.wa = wa; r.wd = wd; r.re = re; r.ra = ra; r.iv = iv; r.ind = ind; r.rr = rr;
    r.x_wr = x_wr; r.x_rd = x_rd; r.x_tx = x_tx; r.x_pkt = x_pkt;
    r.x_irq = x_irq; r.x_cause = x_cause; r.x_idx = x_idx;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [45:0] got, exp;
    bus.write_en = 0; bus.write_addr = '0; bus.write_data = '0;
    bus.read_en = 0; bus.read_addr = '0;
    bus.in_data_valid = 0; bus.in_data = '0; bus.router_rdy = 1'b1;

    // ---------------- layer_no=2 run, then host handshake corner cases
    tbl.push_back(v(1, 16'h0, 16'h2, 0, 0, 0, 0, 1,  1, 0, 1, pkt(I_CFG, 16'h0, 16'h2), 0, 0, 0));
    tbl.push_back(v(1, A_START, 0, 0, 0, 0, 0, 1,    1, 0, 1, pkt(I_CALC, 0, 0), 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, pkt(I_FBC, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, pkt(I_FBC, 0, 1), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, pkt(I_FCP, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, pkt(I_FBC, 0, 2), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, pkt(I_FBC, 0, 3), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,          0, 0, 1, pkt(I_FBC, 0, 0), 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0, 0, 0, 0, 0, 1, pkt(I_FCP, 0, 16'(k)), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,          0, 0, 1, pkt(I_FCP, 0, 0), 0, 0, 0));
    for (int k = 3; k >= 0; k--)
      tbl.push_back(v(0, 0, 0, 0, 0, 1, pkt(I_FBC, 0, 16'(k)), 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,          0, 0, 1, pkt(I_FBC, 0, 0), 0, 0, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0, 0, 0, 0, 0, 1, pkt(I_FCP, 0, 16'(k)), 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,          0, 0, 1, pkt(I_FCP, 0, 0), 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,          1, 1, 0, 0, 1, 1, 1));
    tbl.push_back(v(1, 16'h10, 16'hABCD, 1, 16'h10, 0, 0, 1, 1, 0, 1, pkt(I_CFG, 16'h10, 16'hABCD), 1, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 16'h10, 0, 0, 1,     1, 1, 1, pkt(I_RD, 16'h10, 0), 1, 1, 1));
    tbl.push_back(v(1, A_CLR, 0, 0, 0, 0, 0, 0,      1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 16'h5, 16'h7, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,          1, 1, 0, 0, 0, 0, 1));

    // ---------------- reset state
    #3;
    chk("reset_regs", {interrupt, irq_cause, layer_idx, bus.comp_tx_en}, {1'b0, 2'd0, 4'd0, 1'b0});
    chk("reset_wr_rdy", bus.write_rdy, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- table
    foreach (tbl[k]) begin
      bus.write_en = tbl[k].we; bus.write_addr = tbl[k].wa; bus.write_data = tbl[k].wd;
      bus.read_en = tbl[k].re; bus.read_addr = tbl[k].ra;
      bus.in_data_valid = tbl[k].iv; bus.in_data = tbl[k].ind; bus.router_rdy = tbl[k].rr;
      #4;
      got = {bus.write_rdy, bus.read_rdy, tx_now(), interrupt, irq_cause, layer_idx};
      exp = {tbl[k].x_wr, tbl[k].x_rd, tbl[k].x_tx, tbl[k].x_tx ? tbl[k].x_pkt : 36'd0,
             tbl[k].x_irq, tbl[k].x_cause, tbl[k].x_idx};
      chk($sformatf("vec%0d", k), 64'(got), 64'(exp));
      tick();
    end
    bus.write_en = 0; bus.read_en = 0; bus.in_data_valid = 0; bus.in_data = '0; bus.router_rdy = 1;

    // ---------------- layer 0 then router stall on layer 1, reset in WAIT_CP
    host_write(A_START, 0, 1, pkt(I_CALC, 0, 0), "stall_start");
    for (int k = 0; k < 4; k++) send_fin(I_FBC, 16'(k));
    expect_tx("l0_fbc", pkt(I_FBC, 0, 0));
    for (int k = 0; k < 4; k++) send_fin(I_FCP, 16'(k));
    expect_tx("l0_fcp", pkt(I_FCP, 0, 0));
    #4 chk("l1_idx", layer_idx, 4'd1);
    tick();
    for (int k = 0; k < 3; k++) send_fin(I_FBC, 16'(k));
    bus.router_rdy = 1'b0;
    send_fin(I_FBC, 16'd3);
    for (int k = 0; k < 5; k++) begin
      #4 chk($sformatf("stall%0d", k), tx_now(), 37'd0);
      tick();
    end
    bus.router_rdy = 1'b1;
    expect_tx("stall_release", pkt(I_FBC, 0, 0));
    #4 chk("after_release", tx_now(), 37'd0);
    tick();
    send_fin(I_FCP, 16'd0);
    send_fin(I_FCP, 16'd1);
    rst_n = 1'b0;
    #4 chk("midrun_reset", {bus.comp_tx_en, layer_idx, interrupt, bus.write_rdy}, {1'b0, 4'd0, 1'b0, 1'b1});
    bus.router_rdy = 1'b0;
    #1 chk("reset_wr_rdy_follow", bus.write_rdy, 1'b0);
    tick();
    rst_n = 1'b1; bus.router_rdy = 1'b1;

    // ---------------- layer_no 0 stored as 1; completion racing watchdog
    host_write(16'h0, 16'h3, 1, pkt(I_CFG, 0, 16'h3), "layer3");
    host_write(16'h0, 16'h0, 1, pkt(I_CFG, 0, 16'h0), "layer0");
    host_write(A_START, 0, 1, pkt(I_CALC, 0, 0), "race_start");
    for (int k = 0; k < 3; k++) send_fin(I_FBC, 16'(k));
    repeat (14) tick();
    send_fin(I_FBC, 16'd3);
    #4 chk("race_irq", {interrupt, irq_cause}, {1'b0, 2'd0});
    chk("race_tx", tx_now(), {1'b1, pkt(I_FBC, 0, 0)});
    tick();
    for (int k = 0; k < 4; k++) send_fin(I_FCP, 16'(k));
    expect_tx("race_fcp", pkt(I_FCP, 0, 0));
    #4 chk("one_layer_done", {interrupt, irq_cause, layer_idx}, {1'b1, 2'd1, 4'd0});
    tick();

    // ---------------- duplicate id -> protocol error, irq-clear
    host_write(A_START, 0, 1, pkt(I_CALC, 0, 0), "dup_start");
    #4 chk("start_clears_irq", {interrupt, irq_cause}, {1'b0, 2'd0});
    tick();
    for (int k = 0; k < 3; k++) send_fin(I_FBC, 16'(k));
    send_fin(I_FBC, 16'd2);
    #4 chk("dup_err", {interrupt, irq_cause, bus.comp_tx_en, bus.write_rdy}, {1'b1, 2'd3, 1'b0, 1'b0});
    tick();
    send_fin(I_FBC, 16'd3);
    #4 chk("err_no_tx", tx_now(), 37'd0);
    bus.write_en = 1'b1; bus.write_addr = 16'h5;
    #1 chk("err_wr_blocked", bus.write_rdy, 1'b0);
    bus.write_addr = A_CLR; bus.router_rdy = 1'b0;
    #1 chk("err_clr_rdy", bus.write_rdy, 1'b1);
    tick();
    bus.write_en = 1'b0; bus.router_rdy = 1'b1;
    #4 chk("clr_to_idle", {bus.write_rdy, interrupt, irq_cause}, {1'b1, 1'b0, 2'd0});
    tick();

    // ---------------- out-of-range id -> protocol error
    host_write(A_START, 0, 1, pkt(I_CALC, 0, 0), "oor_start");
    send_fin(I_FBC, 16'd4);
    #4 chk("oor_err", {interrupt, irq_cause}, {1'b1, 2'd3});
    bus.write_en = 1'b1; bus.write_addr = A_CLR;
    tick();
    bus.write_en = 1'b0;

    // ---------------- watchdog timeout after 15 idle cycles
    host_write(A_START, 0, 1, pkt(I_CALC, 0, 0), "tmo_start");
    repeat (14) tick();
    #4 chk("tmo_early", interrupt, 1'b0);
    tick();
    #4 chk("tmo_err", {interrupt, irq_cause}, {1'b1, 2'd2});
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
